calc_xtor_engine: RTL
=====================

Name: calc_xtor_engine

Overview:
Synthesisable, parametrised calculator transactor engine that replaces per-transaction task-driven stimulus with a hardware command/response pipeline. It accepts calculator commands (A, B, opcode, DUT-reset flag, tag) over a valid/ready port and buffers them in a command FIFO. It drives them onto the calculator DUT pins one at a time, samples the (DATA_W+1)-bit result after a programmable latency, and returns tagged responses through a response FIFO. It sits between the host-side transactor channel and the calculator DUT.

Parameters:
DATA_W, 32, operand width; DUT result is DATA_W+1 bits.
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2).
RSP_DEPTH, 4, response FIFO entries (power of 2, >=2).
TAG_W, 4, transaction tag width.
DUT_LATENCY, 2, clock edges from the DUT-input drive edge to the result capture edge (>=1).

Ports:
clk  in  1  single clock; all logic on posedge.
reset_high  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  command FIFO not full.
cmd_a  in  DATA_W  operand A.
cmd_b  in  DATA_W  operand B.
cmd_op  in  3  opcode.
cmd_rst  in  1  assert DUT reset for this transaction.
cmd_tag  in  TAG_W  tag, echoed in the response.
dut_a  out  DATA_W  to DUT A.
dut_b  out  DATA_W  to DUT B.
dut_opcode  out  3  to DUT opcode.
dut_reset_high  out  1  to DUT reset.
dut_result  in  DATA_W+1  from DUT result.
rsp_valid  out  1  response FIFO not empty.
rsp_ready  in  1  consumer accepts the head response.
rsp_result  out  DATA_W+1  captured result.
rsp_op  out  3  opcode of the transaction.
rsp_tag  out  TAG_W  tag of the transaction.
busy  out  1  state != IDLE or command FIFO not empty.
txn_count  out  16  completed-transaction counter.

Behaviour:
- Reset values (sync, wins over everything): FIFOs empty, state IDLE, cmd_ready=1, rsp_valid=0, busy=0, txn_count=0, dut_a=0, dut_b=0, dut_opcode=0, dut_reset_high=1.
- Reset mid-operation: the in-flight transaction is discarded with no response; all queued commands and responses are dropped.
- Command push: on a posedge with cmd_valid && cmd_ready.
  - cmd_ready = !cmd_full, registered-count based.
  - When full, a push is refused even if a pop occurs on the same edge.
- FSM has two states: IDLE and EXEC.
  - IDLE -> EXEC on an edge where the command FIFO is non-empty and rsp_count < RSP_DEPTH.
  - On that pop edge E: dut_a/dut_b/dut_opcode load from the head entry; dut_reset_high loads cmd_rst; tag and op are latched; the latency counter clears.
  - EXEC: the counter increments each edge.
  - On edge E+DUT_LATENCY: dut_result is sampled and pushed to the response FIFO with {result, op, tag}; txn_count increments; state returns to IDLE; dut_reset_high clears to 0.
  - dut_a/dut_b/dut_opcode hold their last values while IDLE.
- Throughput: one transaction per DUT_LATENCY+1 cycles. Exactly one transaction is in flight at a time.
- Minimum latency with empty FIFOs: command accepted on edge N, popped on N+1, captured on N+1+DUT_LATENCY; rsp_valid is high in the following cycle.
- Backpressure: a full response FIFO blocks the pop in IDLE. A capture never overflows, because the free slot was checked at pop and only the FSM writes the FIFO.
- Response FIFO: first-word-fall-through.
  - rsp_* stay stable while rsp_valid && !rsp_ready.
  - Pop occurs on rsp_valid && rsp_ready.
  - A simultaneous push and pop is legal; the count is unchanged.
- Arithmetic: the result is captured as the full DATA_W+1 bits, with no truncation or sign handling. txn_count wraps 0xFFFF -> 0x0000.
- Ordering: responses are strictly in command order.
- cmd_rst transactions still produce a response, carrying whatever dut_result shows at the capture edge.

Test Plan:
1. Reset release, then push A=5, B=7, op=0, tag=3 (DUT model: op0=add); accepted at edge N -> dut pins 5/7/0 from N+1; rsp_valid after N+3; rsp_result=12, rsp_tag=3; txn_count=1.
2. Overflow width: A=0xFFFFFFFF, B=1, op=0 -> rsp_result=33'h1_0000_0000 intact.
3. Push 6 commands back-to-back, tags 0..5, with rsp_ready=0 -> cmd_ready drops after the FIFO fills. Exactly 4 responses are captured, then the FSM stalls in IDLE with busy=1. Raise rsp_ready -> all 6 responses drain in tag order 0..5, with no drops or duplicates.
4. Command with cmd_rst=1 -> dut_reset_high=1 for exactly DUT_LATENCY cycles from the pop edge, then 0; one response is still emitted.
5. Assert reset_high during EXEC with 2 commands queued -> no response for any of them; all outputs return to reset values on the next edge; txn_count=0.
6. Preload txn_count to 0xFFFF via 65535 transactions (or a force), complete one more -> txn_count=0x0000; rsp stable under rsp_ready toggling.

Source files
------------

// File: rtl/calc_xtor_engine_if.sv
// Calculator transactor bus: host command/response channels plus the DUT pin group.
// slave is the engine's view; master is the host/DUT-side view.
interface calc_xtor_engine_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [2:0]        cmd_op;
  logic              cmd_rst;
  logic [TAG_W-1:0]  cmd_tag;

  logic [DATA_W-1:0] dut_a;
  logic [DATA_W-1:0] dut_b;
  logic [2:0]        dut_opcode;
  logic              dut_reset_high;
  logic [DATA_W:0]   dut_result;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W:0]   rsp_result;
  logic [2:0]        rsp_op;
  logic [TAG_W-1:0]  rsp_tag;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_rst, cmd_tag, dut_result, rsp_ready,
    output cmd_ready, dut_a, dut_b, dut_opcode, dut_reset_high,
           rsp_valid, rsp_result, rsp_op, rsp_tag
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_rst, cmd_tag, dut_result, rsp_ready,
    input  cmd_ready, dut_a, dut_b, dut_opcode, dut_reset_high,
           rsp_valid, rsp_result, rsp_op, rsp_tag
  );
endinterface

// File: rtl/calc_xtor_engine.sv
// Calculator transactor engine: queues commands, drives the DUT one at a time, returns tagged results.
// Latency: accept N, pop N+1, capture N+1+DUT_LATENCY, rsp_valid the cycle after.
// Backpressure: cmd_ready drops when the command FIFO is full; a full response FIFO stalls the pop.

// Generic synchronous FIFO with first-word-fall-through output; push is refused when full.
module calc_xtor_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module calc_xtor_engine #(
  parameter int DATA_W      = 32,
  parameter int CMD_DEPTH   = 4,
  parameter int RSP_DEPTH   = 4,
  parameter int TAG_W       = 4,
  parameter int DUT_LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset_high,
  calc_xtor_engine_if.slave   bus,
  output logic                busy,
  output logic [15:0]         txn_count
);
  localparam int LCW = $clog2(DUT_LATENCY) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        op;
    logic              rst;
    logic [TAG_W-1:0]  tag;
  } cmd_t;

  typedef struct packed {
    logic [DATA_W:0]  result;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t           state, state_nxt;
  cmd_t             cmd_in, cmd_head;
  rsp_t             rsp_in, rsp_head;
  logic             cmd_full, cmd_empty, cmd_pop;
  logic             rsp_full, rsp_empty, rsp_push;
  logic [LCW-1:0]   lat_cnt;
  logic [2:0]       cur_op;
  logic [TAG_W-1:0] cur_tag;

  assign cmd_in = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op, rst: bus.cmd_rst, tag: bus.cmd_tag};

  calc_xtor_fifo #(.W($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst   (reset_high),
    .push  (bus.cmd_valid),
    .din   (cmd_in),
    .pop   (cmd_pop),
    .dout  (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  assign rsp_in = '{result: bus.dut_result, op: cur_op, tag: cur_tag};

  // Capture cannot overflow: a free slot was guaranteed at pop and only the FSM pushes.
  calc_xtor_fifo #(.W($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk   (clk),
    .rst   (reset_high),
    .push  (rsp_push),
    .din   (rsp_in),
    .pop   (bus.rsp_ready),
    .dout  (rsp_head),
    .full  (rsp_full),
    .empty (rsp_empty)
  );

  assign bus.cmd_ready  = !cmd_full;
  assign bus.rsp_valid  = !rsp_empty;
  assign bus.rsp_result = rsp_head.result;
  assign bus.rsp_op     = rsp_head.op;
  assign bus.rsp_tag    = rsp_head.tag;
  assign busy           = (state != IDLE) || !cmd_empty;

  always_ff @(posedge clk) begin
    if (reset_high) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_pop   = 1'b0;
    rsp_push  = 1'b0;
    case (state)
      IDLE: if (!cmd_empty && !rsp_full) begin
        cmd_pop   = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: if (lat_cnt == LCW'(DUT_LATENCY - 1)) begin
        rsp_push  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_high) begin
      bus.dut_a          <= '0;
      bus.dut_b          <= '0;
      bus.dut_opcode     <= '0;
      bus.dut_reset_high <= 1'b1;
      lat_cnt            <= '0;
      cur_op             <= '0;
      cur_tag            <= '0;
      txn_count          <= '0;
    end else begin
      if (cmd_pop) begin
        bus.dut_a          <= cmd_head.a;
        bus.dut_b          <= cmd_head.b;
        bus.dut_opcode     <= cmd_head.op;
        bus.dut_reset_high <= cmd_head.rst;
        cur_op             <= cmd_head.op;
        cur_tag            <= cmd_head.tag;
        lat_cnt            <= '0;
      end else if (state == EXEC) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
      if (rsp_push) begin
        txn_count          <= txn_count + 16'd1;
        bus.dut_reset_high <= 1'b0;
      end
    end
  end
endmodule
